// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for the shared-memory MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback, with a bounded memory wait and sticky traps.
module multicycle_control #(
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 0,
  parameter int CNT_W       = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [5:0]         Op_i,
  input  logic               Zero_i,
  input  logic               mem_ready_i,
  output logic               PCWrite_o,
  output logic               IorD_o,
  output logic               MemRead_o,
  output logic               MemWrite_o,
  output logic               IRWrite_o,
  output logic               MemtoReg_o,
  output logic               RegDst_o,
  output logic               RegWrite_o,
  output logic               ALUSrcA_o,
  output logic [1:0]         ALUSrcB_o,
  output logic [ALUOP_W-1:0] ALUOp_o,
  output logic [1:0]         PCSource_o,
  output logic [3:0]         state_o,
  output logic               illegal_o,
  output logic               timeout_o
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12,
    S_TRAP   = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);

  localparam bit             TIMEOUT_EN  = (MEM_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic             mem_wait;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    mem_wait   = 1'b0;
    PCWrite_o  = 1'b0;
    IorD_o     = 1'b0;
    MemRead_o  = 1'b0;
    MemWrite_o = 1'b0;
    IRWrite_o  = 1'b0;
    MemtoReg_o = 1'b0;
    RegDst_o   = 1'b0;
    RegWrite_o = 1'b0;
    ALUSrcA_o  = 1'b0;
    ALUSrcB_o  = 2'd0;
    ALUOp_o    = ALU_ADD;
    PCSource_o = 2'd0;

    case (state_q)
      S_IDLE: if (start_i) state_d = S_FETCH;
      S_FETCH: begin
        MemRead_o = 1'b1;
        ALUSrcB_o = 2'd1;
        if (mem_ready_i) begin
          IRWrite_o = 1'b1;
          PCWrite_o = 1'b1;
          state_d   = S_DECODE;
        end else begin
          mem_wait = 1'b1;
        end
      end
      // Branch target is precomputed here while the opcode is decoded.
      S_DECODE: begin
        ALUSrcB_o = 2'd3;
        case (Op_i)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'd2;
        state_d   = (Op_i == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead_o = 1'b1;
        IorD_o    = 1'b1;
        if (mem_ready_i) state_d = S_MEMWB;
        else             mem_wait = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg_o = 1'b1;
        RegWrite_o = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite_o = 1'b1;
        IorD_o     = 1'b1;
        if (mem_ready_i) state_d = S_FETCH;
        else             mem_wait = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA_o = 1'b1;
        ALUOp_o   = ALU_FUNCT;
        state_d   = S_RWB;
      end
      S_RWB: begin
        RegDst_o   = 1'b1;
        RegWrite_o = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA_o  = 1'b1;
        ALUOp_o    = ALU_SUB;
        PCSource_o = 2'd1;
        PCWrite_o  = Zero_i;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        PCSource_o = 2'd2;
        PCWrite_o  = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'd2;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite_o = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP: ;
      default: state_d = S_TRAP;
    endcase

    // A ready in the limit cycle never reaches here, so completion beats timeout.
    if (mem_wait) begin
      if (TIMEOUT_EN && (cnt_q == TIMEOUT_CNT)) begin
        state_d   = S_TRAP;
        timeout_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (state_d != state_q) cnt_d = '0;
  end

  assign state_o   = state_q;
  assign illegal_o = illegal_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: two instances (no timeout / timeout 5) share stimulus
// and are each checked against an instruction-level reference model.
module tb_multicycle_control;

  localparam int TMO = 5;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [5:0] Op_i;
  logic       Zero_i;
  logic       mem_ready_i;

  logic       pcwrite  [2];
  logic       iord     [2];
  logic       memread  [2];
  logic       memwrite [2];
  logic       irwrite  [2];
  logic       memtoreg [2];
  logic       regdst   [2];
  logic       regwrite [2];
  logic       alusrca  [2];
  logic [1:0] alusrcb  [2];
  logic [1:0] aluop    [2];
  logic [1:0] pcsource [2];
  logic [3:0] state    [2];
  logic       illegal  [2];
  logic       timeout  [2];

  always #5 clk_i = ~clk_i;

  multicycle_control #(.ALUOP_W(2), .MEM_TIMEOUT(0), .CNT_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .Op_i(Op_i), .Zero_i(Zero_i),
    .mem_ready_i(mem_ready_i), .PCWrite_o(pcwrite[0]), .IorD_o(iord[0]),
    .MemRead_o(memread[0]), .MemWrite_o(memwrite[0]), .IRWrite_o(irwrite[0]),
    .MemtoReg_o(memtoreg[0]), .RegDst_o(regdst[0]), .RegWrite_o(regwrite[0]),
    .ALUSrcA_o(alusrca[0]), .ALUSrcB_o(alusrcb[0]), .ALUOp_o(aluop[0]),
    .PCSource_o(pcsource[0]), .state_o(state[0]), .illegal_o(illegal[0]), .timeout_o(timeout[0])
  );

  multicycle_control #(.ALUOP_W(2), .MEM_TIMEOUT(TMO), .CNT_W(8)) dut_to (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .Op_i(Op_i), .Zero_i(Zero_i),
    .mem_ready_i(mem_ready_i), .PCWrite_o(pcwrite[1]), .IorD_o(iord[1]),
    .MemRead_o(memread[1]), .MemWrite_o(memwrite[1]), .IRWrite_o(irwrite[1]),
    .MemtoReg_o(memtoreg[1]), .RegDst_o(regdst[1]), .RegWrite_o(regwrite[1]),
    .ALUSrcA_o(alusrca[1]), .ALUSrcB_o(alusrcb[1]), .ALUOp_o(aluop[1]),
    .PCSource_o(pcsource[1]), .state_o(state[1]), .illegal_o(illegal[1]), .timeout_o(timeout[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: current state, wait count, sticky flags and the remaining
  // post-decode state sequence of the instruction in flight.
  int m_st   [2];
  int m_cnt  [2];
  bit m_ill  [2];
  bit m_to   [2];
  int m_plan [2][3];
  int m_n    [2];
  int m_idx  [2];
  int wlen;

  function automatic logic [14:0] ctrl_of(input int i);
    return {pcwrite[i], iord[i], memread[i], memwrite[i], irwrite[i], memtoreg[i],
            regdst[i], regwrite[i], alusrca[i], alusrcb[i], aluop[i], pcsource[i]};
  endfunction

  function automatic logic [14:0] exp_ctrl(input int st, input bit rdy, input bit z);
    bit pcw = 0, iod = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rdst = 0, rw = 0, srca = 0;
    logic [1:0] srcb = 0, op = 0, pcs = 0;
    case (st)
      1:  begin mrd = 1; srcb = 1; irw = rdy; pcw = rdy; end
      2:  srcb = 3;
      3:  begin srca = 1; srcb = 2; end
      4:  begin mrd = 1; iod = 1; end
      5:  begin m2r = 1; rw = 1; end
      6:  begin mwr = 1; iod = 1; end
      7:  begin srca = 1; op = 2; end
      8:  begin rdst = 1; rw = 1; end
      9:  begin srca = 1; op = 1; pcs = 1; pcw = z; end
      10: begin pcs = 2; pcw = 1; end
      11: begin srca = 1; srcb = 2; end
      12: rw = 1;
      default: ;
    endcase
    return {pcw, iod, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, op, pcs};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_cnt[i] = 0; m_ill[i] = 0; m_to[i] = 0; m_n[i] = 0; m_idx[i] = 0;
    end
  endtask

  task automatic advance(input int i, output int nx);
    if (m_idx[i] < m_n[i]) begin
      nx = m_plan[i][m_idx[i]];
      m_idx[i]++;
    end else begin
      nx = 1;
    end
  endtask

  task automatic load_plan(input int i);
    m_idx[i] = 0;
    case (Op_i)
      6'b000000: begin m_n[i] = 2; m_plan[i][0] = 7;  m_plan[i][1] = 8; end
      6'b100011: begin m_n[i] = 3; m_plan[i][0] = 3;  m_plan[i][1] = 4; m_plan[i][2] = 5; end
      6'b101011: begin m_n[i] = 2; m_plan[i][0] = 3;  m_plan[i][1] = 6; end
      6'b000100: begin m_n[i] = 1; m_plan[i][0] = 9;  end
      6'b000010: begin m_n[i] = 1; m_plan[i][0] = 10; end
      6'b001000: begin m_n[i] = 2; m_plan[i][0] = 11; m_plan[i][1] = 12; end
      default:   m_n[i] = 0;
    endcase
  endtask

  task automatic model_step(input int i, input int tmo);
    int nx;
    nx = m_st[i];
    case (m_st[i])
      0: if (start_i) nx = 1;
      1, 4, 6: begin
        if (mem_ready_i) begin
          if (m_st[i] == 1) nx = 2;
          else advance(i, nx);
        end else if (tmo > 0 && m_cnt[i] == tmo) begin
          nx = 15;
          m_to[i] = 1;
        end else begin
          m_cnt[i]++;
        end
      end
      2: begin
        load_plan(i);
        if (m_n[i] == 0) begin
          nx = 15;
          m_ill[i] = 1;
        end else begin
          advance(i, nx);
        end
      end
      15: ;
      default: advance(i, nx);
    endcase
    if (nx != m_st[i]) m_cnt[i] = 0;
    m_st[i] = nx;
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("state[%0d]", i), 32'(state[i]), 32'(m_st[i]));
      check_eq($sformatf("ctrl[%0d]", i), 32'(ctrl_of(i)),
               32'(exp_ctrl(m_st[i], mem_ready_i, Zero_i)));
      check_eq($sformatf("illegal[%0d]", i), 32'(illegal[i]), 32'(m_ill[i]));
      check_eq($sformatf("timeout[%0d]", i), 32'(timeout[i]), 32'(m_to[i]));
    end
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] legal [6];
    legal[0] = 6'b000000; legal[1] = 6'b100011; legal[2] = 6'b101011;
    legal[3] = 6'b000100; legal[4] = 6'b000010; legal[5] = 6'b001000;
    if ($urandom_range(0, 9) == 0) return 6'($urandom);
    return legal[$urandom_range(0, 5)];
  endfunction

  task automatic randomize_inputs();
    start_i     = 1'($urandom);
    Op_i        = 6'($urandom);
    Zero_i      = 1'($urandom);
    mem_ready_i = 1'($urandom);
  endtask

  // Enters and leaves at a falling edge; async reset is checked while held.
  task automatic reset_seq();
    rst_i = 1'b0;
    model_reset();
    repeat (3) begin
      randomize_inputs();
      start_i = 1'b1;
      #1;
      check_all();
      @(negedge clk_i);
    end
    rst_i = 1'b1;
  endtask

  // One clock: drive inputs, check outputs mid-cycle, advance the model, wait for next falling edge.
  task automatic cycle_step(input bit force_start);
    start_i = force_start ? 1'b1 : 1'($urandom);
    Zero_i  = 1'($urandom);
    if (m_st[0] == 1 || m_st[0] == 4 || m_st[0] == 6) begin
      if (m_cnt[0] == 0) begin
        wlen = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 7));
        if (m_st[0] == 1) Op_i = pick_op();
      end
      mem_ready_i = (m_cnt[0] >= wlen);
    end else begin
      mem_ready_i = 1'($urandom);
    end
    #1;
    check_all();
    model_step(0, 0);
    model_step(1, TMO);
    @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b0;
    start_i = 1'b0;
    Op_i = 6'd0;
    Zero_i = 1'b0;
    mem_ready_i = 1'b0;
    wlen = 0;
    model_reset();
    @(negedge clk_i);
    for (int run = 0; run < 40; run++) begin
      int len;
      reset_seq();
      len = int'($urandom_range(30, 90));
      for (int c = 0; c < len; c++) cycle_step(c == 0);
      $display("[TB] run %0d: %0d cycles, dut state %0d illegal %0d, dut_to state %0d timeout %0d",
               run, len, m_st[0], m_ill[0], m_st[1], m_to[1]);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Sequential (multi-cycle) main control FSM for the MIPS datapath; replaces the single-cycle opcode decoder.
- Sequences fetch, decode, execute, memory and writeback over several clocks.
- Waits on a memory ready handshake, bounds that wait with an optional timeout, and traps on illegal opcodes.
- Sits between the instruction register opcode field and the shared-memory multi-cycle datapath.

Parameters:
- ALUOP_W, 2, ALUOp_o width (>=2). Codes are zero-extended: 0 = add, 1 = sub, 2 = funct-decode.
- MEM_TIMEOUT, 0, maximum wait cycles per memory access. 0 disables the timeout.
- CNT_W, 8, width of the wait counter. Requires MEM_TIMEOUT < 2^CNT_W.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  leave IDLE and begin fetching
- Op_i  in  6  opcode from instruction register
- Zero_i  in  1  ALU zero flag
- mem_ready_i  in  1  memory access completes this cycle
- PCWrite_o  out  1  load PC (already qualified by Zero_i for beq)
- IorD_o  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- MemRead_o  out  1  memory read
- MemWrite_o  out  1  memory write
- IRWrite_o  out  1  load instruction register
- MemtoReg_o  out  1  register write data select: 1 = MDR
- RegDst_o  out  1  1 = rd, 0 = rt
- RegWrite_o  out  1  register file write
- ALUSrcA_o  out  1  0 = PC, 1 = rs
- ALUSrcB_o  out  2  0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm<<2
- ALUOp_o  out  ALUOP_W  ALU operation code
- PCSource_o  out  2  0 = ALU, 1 = ALUOut, 2 = jump target
- state_o  out  4  current state encoding (debug)
- illegal_o  out  1  sticky: illegal opcode trapped
- timeout_o  out  1  sticky: memory wait timeout

Behaviour:
- Reset (rst_i=0, async):
  - state = IDLE, counter = 0, illegal_o = timeout_o = 0.
  - All control outputs are 0 during and after reset while in IDLE.
- State encodings: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, RWB 8, BRANCH 9, JUMP 10, ADDIEX 11, ADDIWB 12, TRAP 15.
- Outputs are decoded combinationally from state (plus mem_ready_i and Zero_i where noted). Any output not listed for a state is 0.
- IDLE: go to FETCH when start_i=1.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=add, PCSource=0.
  - IRWrite and PCWrite assert only in the cycle mem_ready_i=1; go to DECODE then. Otherwise hold.
- DECODE:
  - ALUSrcA=0, ALUSrcB=3, ALUOp=add (precomputes the branch target).
  - Next state by opcode: 000000 -> EXEC; 100011/101011 -> MEMADR; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> ADDIEX.
  - Any other opcode -> TRAP with illegal_o set.
- EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=funct -> RWB.
- RWB: RegDst=1, RegWrite=1, MemtoReg=0 -> FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=add.
  - Go to MEMRD for lw, MEMWR for sw; opcode is re-sampled from Op_i, which the instruction register holds stable.
- MEMRD: MemRead=1, IorD=1; hold until mem_ready_i, then MEMWB.
- MEMWB: RegDst=0, RegWrite=1, MemtoReg=1 -> FETCH.
- MEMWR: MemWrite=1, IorD=1; hold until mem_ready_i, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=sub, PCSource=1, PCWrite=Zero_i -> FETCH.
- JUMP: PCSource=2, PCWrite=1 -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=2, ALUOp=add -> ADDIWB.
- ADDIWB: RegDst=0, RegWrite=1, MemtoReg=0 -> FETCH.
- Cycle counts with zero-wait memory: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.
- Memory wait counter:
  - Clears on entry to FETCH, MEMRD or MEMWR and increments each cycle spent waiting there with mem_ready_i=0.
  - If MEM_TIMEOUT>0 and the counter equals MEM_TIMEOUT while mem_ready_i=0, go to TRAP and set timeout_o.
  - mem_ready_i=1 in that same cycle wins: the access completes and no timeout occurs.
- TRAP: all control outputs 0; stays until reset. The sticky flags clear only on reset.
- start_i is ignored outside IDLE; the FSM never returns to IDLE except via reset.
- Reset asserted mid-instruction aborts immediately; no partial write is issued after the reset edge.

Test Plan:
- Reset with start_i=1 and all inputs random -> every output 0 and state_o=0 while rst_i=0; state_o=1 on the first clock after release.
- Op_i=000000, mem_ready_i=1 constant -> states 1,2,7,8,1. RegWrite=RegDst=1 only in state 8; ALUOp=2 in state 7.
- Op_i=100011, mem_ready_i held low 3 cycles in MEMRD, MEM_TIMEOUT=0 -> MEMRD lasts 4 cycles with MemRead=IorD=1; MEMWB asserts RegWrite=MemtoReg=1.
- Op_i=000100, Zero_i=1 and then Zero_i=0 in BRANCH -> PCWrite=1 with PCSource=1 in the first case; PCWrite=0 in the second.
- Op_i=111111 -> DECODE goes to TRAP, illegal_o=1, outputs stay 0 for 20 cycles; start_i toggling has no effect.
- MEM_TIMEOUT=5, mem_ready_i=0 in FETCH -> TRAP after 6 FETCH cycles with timeout_o=1. A repeat run raising mem_ready_i in the limit cycle goes to DECODE with no timeout.
